// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// The read-return pipeline carries one rd_tag_t per stage, naming which
// requester owns the read data that the memory returns at the pipeline tail.
package dmem_arb_pkg;

    // Requester identifier: port 0 is the CPU load/store path, port 1 the loader/DMA.
    typedef logic port_id_t;

    localparam port_id_t PORT_CPU = 1'b0;
    localparam port_id_t PORT_DMA = 1'b1;

    // One in-flight read: valid marks a real read, port names its owner.
    typedef struct packed {
        logic     valid;
        port_id_t port;
    } rd_tag_t;

    // Deepest memory read latency the return pipeline supports.
    localparam int unsigned MAX_READ_LAT = 4;

    // Empty pipeline stage.
    localparam rd_tag_t RD_TAG_IDLE = '{valid: 1'b0, port: PORT_CPU};

    // Round-robin choice for a contested cycle: the port that did not win last.
    function automatic port_id_t rr_winner(input port_id_t last_gnt);
        return (last_gnt == PORT_CPU) ? PORT_DMA : PORT_CPU;
    endfunction

endpackage

// File: rtl/dmem_arb_rdpipe.sv
// Read-return tracker for the data-memory arbiter.
// A DEPTH-stage shift register of rd_tag_t; a tag entering in cycle t reaches
// the tail in cycle t + DEPTH, lined up with the memory's read data.
// Synchronous clear drops every tracked read.
module dmem_arb_rdpipe
    import dmem_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic    clk_i,
    input  logic    clr_i,
    input  rd_tag_t tag_i,
    output rd_tag_t tag_o
);

    rd_tag_t stage_q [DEPTH];

    // Advance every tag one stage per cycle; clear empties all stages.
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage_q[i] <= RD_TAG_IDLE;
            end
        end else begin
            stage_q[0] <= tag_i;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory.
// Port 0 is the CPU load/store path, port 1 the loader/DMA master.
// Grants are combinational same-cycle accepts, at most one per cycle; read
// data returns to its owner READ_LAT cycles after the grant.
// Optional build macro DMEM_ARB_CPU_PRIORITY_EN: when defined, port 0 always
// wins a contested cycle; otherwise contested cycles alternate round-robin.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned READ_LAT   = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  req0_i,
    input  logic                  we0_i,
    input  logic [ADDR_WIDTH-1:0] addr0_i,
    input  logic [DATA_WIDTH-1:0] wdata0_i,
    output logic                  gnt0_o,
    output logic                  rvalid0_o,
    output logic [DATA_WIDTH-1:0] rdata0_o,

    input  logic                  req1_i,
    input  logic                  we1_i,
    input  logic [ADDR_WIDTH-1:0] addr1_i,
    input  logic [DATA_WIDTH-1:0] wdata1_i,
    output logic                  gnt1_o,
    output logic                  rvalid1_o,
    output logic [DATA_WIDTH-1:0] rdata1_o,

    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic                  mem_we_o,
    output logic                  mem_re_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,

    output logic                  cpu_stall_o
);

    if (READ_LAT == 0 || READ_LAT > MAX_READ_LAT) begin : g_bad_read_lat
        $error("dmem_arbiter: READ_LAT must be in 1..%0d", MAX_READ_LAT);
    end

    // High for the cycle following reset.
    logic     rst_q;
    // Port granted on the most recent grant of any kind.
    port_id_t last_gnt_q;

    // Grants, strobes and returns are all suppressed while in reset and for
    // one cycle after it, so the memory sees a clean quiet cycle.
    logic     blank;

    logic     gnt_valid;
    port_id_t gnt_port;
    port_id_t contested_winner;
    logic     sel_we;

    rd_tag_t  rd_tag_in;
    rd_tag_t  rd_tag_out;

    assign blank = rst_i | rst_q;

`ifdef DMEM_ARB_CPU_PRIORITY_EN
    // Fixed priority: the CPU always wins; last_gnt_q is tracked but unused here.
    assign contested_winner = PORT_CPU;
`else
    assign contested_winner = rr_winner(last_gnt_q);
`endif

    // Track the post-reset blank cycle and the last granted port.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rst_q      <= 1'b1;
            last_gnt_q <= PORT_DMA;
        end else begin
            rst_q <= 1'b0;
            if (gnt_valid) begin
                last_gnt_q <= gnt_port;
            end
        end
    end

    // Pick at most one winner among the requesting ports.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_port  = PORT_CPU;
        if (!blank) begin
            unique case ({req1_i, req0_i})
                2'b01: begin
                    gnt_valid = 1'b1;
                    gnt_port  = PORT_CPU;
                end
                2'b10: begin
                    gnt_valid = 1'b1;
                    gnt_port  = PORT_DMA;
                end
                2'b11: begin
                    gnt_valid = 1'b1;
                    gnt_port  = contested_winner;
                end
                default: begin
                    gnt_valid = 1'b0;
                    gnt_port  = PORT_CPU;
                end
            endcase
        end
    end

    // Route the granted port's request to the memory; port 0 drives when idle.
    always_comb begin
        if (gnt_port == PORT_DMA) begin
            mem_addr_o  = addr1_i;
            mem_wdata_o = wdata1_i;
            sel_we      = we1_i;
        end else begin
            mem_addr_o  = addr0_i;
            mem_wdata_o = wdata0_i;
            sel_we      = we0_i;
        end
        mem_we_o = gnt_valid & sel_we;
        mem_re_o = gnt_valid & ~sel_we;
    end

    // Per-port grant and stall flags.
    always_comb begin
        gnt0_o      = gnt_valid & (gnt_port == PORT_CPU);
        gnt1_o      = gnt_valid & (gnt_port == PORT_DMA);
        cpu_stall_o = ~blank & req0_i & ~gnt0_o;
    end

    // Tag every read grant with its owner as it enters the return pipeline.
    always_comb begin
        rd_tag_in       = RD_TAG_IDLE;
        rd_tag_in.valid = mem_re_o;
        rd_tag_in.port  = gnt_port;
    end

    dmem_arb_rdpipe #(
        .DEPTH (READ_LAT)
    ) u_rdpipe (
        .clk_i (clk_i),
        .clr_i (rst_i),
        .tag_i (rd_tag_in),
        .tag_o (rd_tag_out)
    );

    // Steer returning read data to its owner; zero on the other port.
    always_comb begin
        rvalid0_o = ~blank & rd_tag_out.valid & (rd_tag_out.port == PORT_CPU);
        rvalid1_o = ~blank & rd_tag_out.valid & (rd_tag_out.port == PORT_DMA);
        rdata0_o  = rvalid0_o ? mem_rdata_i : '0;
        rdata1_o  = rvalid1_o ? mem_rdata_i : '0;
    end

endmodule
